// File: rtl/bitmanip_multicycle_unit.sv
// Iterative bext/bdep unit: scans BITS_PER_CYCLE mask bits per cycle, with an early exit once the remaining mask bits are zero.
// Latency: 1 .. L/BITS_PER_CYCLE cycles from acceptance to valid_o (L = 32 in word mode, XLEN otherwise).
// Backpressure: single outstanding op; ready_o only in IDLE; the result is held in DONE until ready_i.
module bitmanip_multicycle_unit #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 8,
    parameter int TRANS_ID_BITS  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     op_i,
    input  logic                     word_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(XLEN);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [XLEN-1:0] WORD_MASK = XLEN'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                     state;
    logic [XLEN-1:0]            a_q;
    logic [XLEN-1:0]            b_q;
    logic [XLEN-1:0]            res_q;
    logic                       op_q;
    logic                       word_q;
    logic [CNT_W-1:0]           i_q;
    logic [CNT_W-1:0]           k_q;
    logic [TRANS_ID_BITS-1:0]   tag_q;

    logic [XLEN-1:0]            res_n;
    logic [XLEN-1:0]            res_final;
    logic [CNT_W-1:0]           k_n;
    logic [CNT_W-1:0]           i_next;
    logic [CNT_W-1:0]           lim;
    logic [IDX_W-1:0]           j_idx;
    logic                       scan_done;

    // One chunk of the scan; k only advances on set mask bits, so it is always in range when used as an index.
    always_comb begin
        res_n = res_q;
        k_n   = k_q;
        j_idx = '0;
        for (int c = 0; c < BITS_PER_CYCLE; c++) begin
            j_idx = i_q[IDX_W-1:0] + IDX_W'(c);
            if (b_q[j_idx]) begin
                if (op_q) begin
                    res_n[j_idx] = a_q[k_n[IDX_W-1:0]];
                end else begin
                    res_n[k_n[IDX_W-1:0]] = a_q[j_idx];
                end
                k_n = k_n + CNT_W'(1);
            end
        end
    end

    always_comb begin
        i_next    = i_q + CNT_W'(BITS_PER_CYCLE);
        lim       = word_q ? CNT_W'(32) : CNT_W'(XLEN);
        scan_done = (i_next >= lim) || ((b_q >> i_next) == '0);
        res_final = res_n;
        if (word_q) begin
            for (int b = 32; b < XLEN; b++) begin
                res_final[b] = res_n[31];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            op_q       <= 1'b0;
            word_q     <= 1'b0;
            i_q        <= '0;
            k_q        <= '0;
            tag_q      <= '0;
        end else if (flush_i && state != IDLE) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        state   <= BUSY;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        a_q     <= word_i ? (operand_a_i & WORD_MASK) : operand_a_i;
                        b_q     <= word_i ? (operand_b_i & WORD_MASK) : operand_b_i;
                        op_q    <= op_i;
                        word_q  <= word_i;
                        tag_q   <= trans_id_i;
                        res_q   <= '0;
                        i_q     <= '0;
                        k_q     <= '0;
                    end
                end
                BUSY: begin
                    res_q <= res_n;
                    k_q   <= k_n;
                    i_q   <= i_next;
                    if (scan_done) begin
                        state      <= DONE;
                        valid_o    <= 1'b1;
                        result_o   <= res_final;
                        trans_id_o <= tag_q;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmanip_multicycle_unit.sv
// Directed bench for bitmanip_multicycle_unit at XLEN=64, BITS_PER_CYCLE=8.
module tb_bitmanip_multicycle_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        op_i = 1'b0;
    logic        word_i = 1'b0;
    logic [63:0] operand_a_i = '0;
    logic [63:0] operand_b_i = '0;
    logic [2:0]  trans_id_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [63:0] result_o;
    logic [2:0]  trans_id_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    bitmanip_multicycle_unit #(.XLEN(64), .BITS_PER_CYCLE(8), .TRANS_ID_BITS(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .word_i(word_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .trans_id_i(trans_id_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .trans_id_o(trans_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drives one request; returns #1 after the edge that accepts it.
    task automatic issue(input logic op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] tag);
        @(negedge clk_i);
        op_i = op; word_i = word; operand_a_i = a; operand_b_i = b; trans_id_i = tag;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    // Cycles from the acceptance edge to the first cycle with valid_o; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (result_o !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
        checks++; if (trans_id_o !== 3'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", trans_id_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_bext();
        int lat;
        issue(1'b0, 1'b0, 64'hFFFF_0000_1234_5678, 64'h0000_0000_0000_FF0F, 3'd5);
        checks++; if (busy_o !== 1'b1 || ready_o !== 1'b0) begin failures++; $display("FAIL bext_busy got busy=%b ready=%b exp busy=1 ready=0", busy_o, ready_o); end
        wait_valid(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL bext_latency got=%0d exp=2", lat); end
        checks++; if (result_o !== 64'h568) begin failures++; $display("FAIL bext_result got=%h exp=%h", result_o, 64'h568); end
        checks++; if (trans_id_o !== 3'd5) begin failures++; $display("FAIL bext_tag got=%0d exp=5", trans_id_o); end
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL bext_retire got ready=%b valid=%b exp 1/0", ready_o, valid_o); end
    endtask

    task automatic test_bdep();
        int lat;
        issue(1'b1, 1'b0, 64'h0000_0000_0000_00AB, 64'hF0F0_0000_0000_0000, 3'd2);
        wait_valid(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL bdep_latency got=%0d exp=8", lat); end
        checks++; if (result_o !== 64'hA0B0_0000_0000_0000) begin failures++; $display("FAIL bdep_result got=%h exp=%h", result_o, 64'hA0B0_0000_0000_0000); end
        checks++; if (trans_id_o !== 3'd2) begin failures++; $display("FAIL bdep_tag got=%0d exp=2", trans_id_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_word();
        int lat;
        // Upper operand bits must be ignored in word mode.
        issue(1'b0, 1'b1, 64'hDEAD_0000_8000_0001, 64'hFFFF_0000_8000_0001, 3'd3);
        wait_valid(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL word_bext_latency got=%0d exp=4", lat); end
        checks++; if (result_o !== 64'h3) begin failures++; $display("FAIL word_bext_result got=%h exp=%h", result_o, 64'h3); end
        @(posedge clk_i); #1;
        issue(1'b1, 1'b1, 64'h1, 64'h0000_0000_8000_0000, 3'd4);
        wait_valid(lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL word_bdep_latency got=%0d exp=4", lat); end
        checks++; if (result_o !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL word_bdep_result got=%h exp=%h", result_o, 64'hFFFF_FFFF_8000_0000); end
        checks++; if (trans_id_o !== 3'd4) begin failures++; $display("FAIL word_bdep_tag got=%0d exp=4", trans_id_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        ready_i = 1'b0;
        // bext of a=0xF0, mask=0xFF -> 0xF0, done after chunk 0.
        issue(1'b0, 1'b0, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00FF, 3'd6);
        wait_valid(lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL bp_latency got=%0d exp=1", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            checks++;
            if (valid_o !== 1'b1 || result_o !== 64'hF0 || trans_id_o !== 3'd6 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b res=%h tag=%0d ready=%b exp 1/f0/6/0",
                         c, valid_o, result_o, trans_id_o, ready_o);
            end
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL bp_release got ready=%b valid=%b exp 1/0", ready_o, valid_o); end
        // Accepted on the very next edge; bdep a=0x5 into mask 0x0F00 -> 0x0500.
        issue(1'b1, 1'b0, 64'h5, 64'h0000_0000_0000_0F00, 3'd7);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy_o); end
        wait_valid(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        checks++; if (result_o !== 64'h500 || trans_id_o !== 3'd7) begin failures++; $display("FAIL b2b_result got=%h tag=%0d exp=500 tag=7", result_o, trans_id_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        issue(1'b1, 1'b0, 64'hFF, 64'h8000_0000_0000_0001, 3'd1);
        @(negedge clk_i); @(posedge clk_i);
        @(negedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL flush_idle got ready=%b busy=%b valid=%b exp 1/0/0", ready_o, busy_o, valid_o); end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_valid got=%0d valid cycles exp=0", seen); end
        // Request together with flush in IDLE is dropped.
        @(negedge clk_i);
        flush_i = 1'b1; valid_i = 1'b1; operand_b_i = 64'h1;
        @(posedge clk_i);
        #1 flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1) begin failures++; $display("FAIL flush_idle_req got busy=%b ready=%b exp 0/1", busy_o, ready_o); end
        // bext a=0x8000_0000_0000_0000 mask=MSB|bit0 -> res[1]=1 -> 0x2.
        issue(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 3'd2);
        wait_valid(lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL post_flush_latency got=%0d exp=8", lat); end
        checks++; if (result_o !== 64'h2 || trans_id_o !== 3'd2) begin failures++; $display("FAIL post_flush_result got=%h tag=%0d exp=2 tag=2", result_o, trans_id_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(1'b0, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 64'h0 || trans_id_o !== 3'd0) begin
            failures++; $display("FAIL rst_busy got ready=%b busy=%b valid=%b res=%h tag=%0d", ready_o, busy_o, valid_o, result_o, trans_id_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        ready_i = 1'b0;
        issue(1'b0, 1'b0, 64'h3, 64'h3, 3'd4);
        wait_valid(lat);
        checks++; if (result_o !== 64'h3 || trans_id_o !== 3'd4) begin failures++; $display("FAIL rst_pre_done got res=%h tag=%0d exp 3/4", result_o, trans_id_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 64'h0 || trans_id_o !== 3'd0) begin
            failures++; $display("FAIL rst_done got ready=%b busy=%b valid=%b res=%h tag=%0d", ready_o, busy_o, valid_o, result_o, trans_id_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        ready_i = 1'b1;
        // Zero mask: one cycle, zero result, for both ops.
        issue(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd5);
        wait_valid(lat);
        checks++; if (lat !== 1 || result_o !== 64'h0) begin failures++; $display("FAIL zero_mask_bext got lat=%0d res=%h exp 1/0", lat, result_o); end
        @(posedge clk_i); #1;
        issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd6);
        wait_valid(lat);
        checks++; if (lat !== 1 || result_o !== 64'h0 || trans_id_o !== 3'd6) begin failures++; $display("FAIL zero_mask_bdep got lat=%0d res=%h tag=%0d exp 1/0/6", lat, result_o, trans_id_o); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_bext();
        test_bdep();
        test_word();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
